// File: rtl/prio_scan_pkg.sv
// prio_scan_pkg: shared FSM state type and lowest-set-bit helper
// for the prio_scan_enc priority scanner (widths up to PSE_MAX_N).
package prio_scan_pkg;

  localparam int unsigned PSE_MAX_N = 64;
  localparam int unsigned PSE_MAX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } pse_state_e;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [PSE_MAX_W-1:0] lowest_set(
    input logic [PSE_MAX_N-1:0] v
  );
    logic [PSE_MAX_W-1:0] r;
    r = '0;
    for (int i = PSE_MAX_N - 1; i >= 0; i--) begin
      if (v[i]) r = PSE_MAX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational priority encoder, bit 0 highest.
// Ports: req (N) in; idx (W) lowest set index, any = |req,
// lsb_oh (N) one-hot mask of the lowest set bit (zero if req == 0).
module prio_enc_comb
  import prio_scan_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any,
  output logic [N-1:0] lsb_oh
);

  assign idx    = W'(lowest_set(PSE_MAX_N'(req)));
  assign any    = |req;
  // Two's-complement trick isolates the lowest set bit.
  assign lsb_oh = req & (~req + N'(1));

endmodule

// File: rtl/prio_scan_enc.sv
// prio_scan_enc: sequential priority scanner. Captures an N-bit request
// vector and emits the index of each set bit, bit 0 first, one per beat.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_req input
// handshake; out_valid/out_ready output handshake with out_idx (W),
// out_any (vector nonzero), out_last (final beat), out_cnt (W+1, popcount,
// present only when PSE_COUNT_EN is defined).
module prio_scan_enc
  import prio_scan_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  output logic         out_last
`ifdef PSE_COUNT_EN
  ,
  output logic [W:0]   out_cnt
`endif
);

  pse_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         any_q, any_d;

  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic [N-1:0] enc_oh;

  logic         scan;
  logic         single;
  logic         out_hs;
  logic         in_hs;

  prio_enc_comb #(.N(N)) u_enc (
    .req    (pend_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .lsb_oh (enc_oh)
  );

  assign scan   = (state_q == SCAN);
  // Last beat when nothing (zero vector) or only one bit remains.
  assign single = ~enc_any | ~|(pend_q & ~enc_oh);

  assign out_valid = scan;
  assign out_idx   = enc_idx;
  assign out_any   = any_q;
  assign out_last  = scan & single;

  assign out_hs   = out_valid & out_ready;
  // Accept a new vector in the same cycle the last beat retires.
  assign in_ready = ~scan | (out_ready & single);
  assign in_hs    = in_valid & in_ready;

`ifdef PSE_COUNT_EN
  logic [W:0] cnt_q, cnt_d;

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++) begin
      s = s + (W+1)'(v[i]);
    end
    return s;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (in_hs) cnt_d = popcnt(in_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_cnt = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    any_d   = any_q;
    if (out_hs) begin
      pend_d = pend_q & ~enc_oh;
      if (single) state_d = IDLE;
    end
    // Capture wins over the retire above (back-to-back case).
    if (in_hs) begin
      pend_d  = in_req;
      any_d   = |in_req;
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      any_q   <= any_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_enc.sv
// tb_prio_scan_enc: scoreboard bench for prio_scan_enc; directed cases
// plus randomized vectors with random output back-pressure.
module tb_prio_scan_enc;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_any;
  logic         out_last;
`ifdef PSE_COUNT_EN
  logic [W:0]   out_cnt;
`endif

  always #5 clk = ~clk;

  prio_scan_enc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_any   (out_any),
    .out_last  (out_last)
`ifdef PSE_COUNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] idx;
    logic         any;
    logic         last;
    logic [W:0]   cnt;
  } beat_t;

  beat_t exp_q[$];

  int tests  = 0;
  int fails  = 0;
  int hs_cnt = 0;
  bit rnd    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list the set bits in ascending order, last flag on the
  // highest one; a zero vector yields a single idx-0 beat.
  task automatic push_model(input logic [N-1:0] v);
    beat_t b;
    int    k;
    int    seen;
    k    = $countones(v);
    seen = 0;
    if (k == 0) begin
      b.idx = '0; b.any = 1'b0; b.last = 1'b1; b.cnt = '0;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (v[i]) begin
          seen++;
          b.idx  = W'(i);
          b.any  = 1'b1;
          b.last = (seen == k);
          b.cnt  = (W+1)'(k);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Monitor: pops on every output handshake; checks stall stability.
  logic         stall_q = 1'b0;
  logic [W-1:0] s_idx;
  logic         s_any;
  logic         s_last;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_idx", 32'(out_idx), 32'(s_idx));
        chk("stall_last", 32'(out_last), 32'(s_last));
        chk("stall_any", 32'(out_any), 32'(s_any));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: idx %0d with empty queue",
                   out_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 32'(out_idx), 32'(e.idx));
          chk("beat_any", 32'(out_any), 32'(e.any));
          chk("beat_last", 32'(out_last), 32'(e.last));
`ifdef PSE_COUNT_EN
          chk("beat_cnt", 32'(out_cnt), 32'(e.cnt));
`endif
        end
      end
      stall_q = out_valid && !out_ready;
      s_idx   = out_idx;
      s_any   = out_any;
      s_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [N-1:0] v);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_req   = v;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(v);
        ok = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    in_req   = N'($urandom);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: vector %0h never accepted", v);
    end
  endtask

  task automatic drain();
    bit done;
    done      = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
      tick();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int          h0;
    logic [N-1:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_any", 32'(out_any), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
`ifdef PSE_COUNT_EN
    chk("rst_cnt", 32'(out_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Scan order 1,4,7.
    out_ready = 1'b1;
    send(N'(8'h92));
    drain();

    // Zero vector: one beat, then idle.
    send(N'(8'h00));
    drain();
    chk("zero_idle_rdy", 32'(in_ready), 32'd1);
    chk("zero_idle_vld", 32'(out_valid), 32'd0);

    send(N'(8'hF1));
    drain();

    // Stall with idx 0 held, then release.
    out_ready = 1'b0;
    send(N'(8'h81));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_v", 32'(out_valid), 32'd1);
      chk("stall_i0", 32'(out_idx), 32'd0);
      tick();
    end
    drain();

    // Back-to-back: beats 2,4,5 on consecutive cycles.
    out_ready = 1'b1;
    h0        = hs_cnt;
    in_valid  = 1'b1;
    in_req    = N'(8'h04);
    @(negedge clk);
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    push_model(N'(8'h04));
    tick();
    in_req = N'(8'h30);
    @(negedge clk);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    push_model(N'(8'h30));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    chk("b2b_beats", 32'(hs_cnt - h0), 32'd3);
    drain();

    // Random vectors with random back-pressure.
    rnd = 1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      send(v);
    end
    rnd = 0;
    drain();

    // Reset in the middle of a scan.
    out_ready = 1'b0;
    send(N'(8'hA6));
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_any", 32'(out_any), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
`ifdef PSE_COUNT_EN
    chk("mid_rst_cnt", 32'(out_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_idle", 32'(out_valid), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
